piso_serializer: RTL and testbench

Parallel-in/serial-out stage that sits directly upstream of the sequence detectors. It drives their 1-bit `in` from a stream of parallel words accepted over a valid/ready handshake. Words are shifted out MSB-first, one bit per clock, and back-to-back words produce a gap-free bit stream. Between words the stage holds a fixed idle level.

---
 rtl/ser_pkg.sv | 17 +
 rtl/ser_bit_cnt.sv | 56 +++++
 rtl/piso_serializer.sv | 193 +++++++++++++++++++
 tb/tb_piso_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
// Shared types and constants for the parallel-in/serial-out serializer.
//   ser_state_t        : FSM encoding of the serializer.
//   SER_DEFAULT_WIDTH  : default word width of the serializer and its counter.
// ----------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_t;

    localparam int SER_DEFAULT_WIDTH = 8;

endpackage : ser_pkg

// File: rtl/ser_bit_cnt.sv
// ----------------------------------------------------------------------------
// ser_bit_cnt
// Loadable down-counter with a zero flag. Counts the bits of a word still to
// be placed on the serial line after the one currently driven.
//
// Parameters:
//   WIDTH    : bits per word; counter is $clog2(WIDTH) bits wide.
// Ports:
//   clk      : system clock, rising edge.
//   rstn     : asynchronous active-low reset (count clears to 0).
//   load     : load load_val this cycle (has priority over dec).
//   load_val : value to load.
//   dec      : decrement by one; ignored when the count is already 0.
//   count    : current count.
//   zero     : count == 0.
// ----------------------------------------------------------------------------
module ser_bit_cnt
    import ser_pkg::*;
#(
    parameter  int WIDTH = SER_DEFAULT_WIDTH,
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            // Saturate at zero: the owning FSM leaves the shift state there.
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule : ser_bit_cnt

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
// Accepts parallel words over a valid/ready handshake and shifts them out
// MSB-first, one bit per clock. Consecutive words form a gap-free stream;
// between words ser_out sits at IDLE_BIT.
//
// Optional feature (macro SER_PARITY_EN): each word is followed by one
// even-parity bit (XOR of the word); word_done and the back-to-back accept
// window then fall on the parity cycle instead of the LSB cycle.
//
// Parameters:
//   WIDTH      : bits per word (>= 2).
//   IDLE_BIT   : level driven on ser_out while no word is being shifted.
// Ports:
//   clk        : system clock, rising edge.
//   rstn       : asynchronous active-low reset.
//   data_in    : parallel word, sampled only on a handshake.
//   data_valid : upstream offers data_in.
//   data_ready : stage accepts a word on this edge (combinational).
//   ser_out    : serial bit (registered).
//   ser_active : ser_out carries a data or parity bit (registered).
//   word_done  : final bit of a word is on ser_out (registered).
// ----------------------------------------------------------------------------
module piso_serializer
    import ser_pkg::*;
#(
    parameter  int   WIDTH    = SER_DEFAULT_WIDTH,
    parameter  logic IDLE_BIT = 1'b0,
    localparam int   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             word_done
);

    ser_state_t       state_reg;
    ser_state_t       state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             ser_out_reg;
    logic             ser_out_next;
    logic             ser_active_reg;
    logic             ser_active_next;
    logic             word_done_reg;
    logic             word_done_next;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CW-1:0]    cnt_val;
    logic             cnt_zero;

    logic             last_bit;
    logic             accept;

    // ------------------------------------------------------------------
    // Bit counter: holds the number of word bits still to follow the one
    // currently on ser_out (WIDTH-1 while the MSB is out, 0 at the LSB).
    // ------------------------------------------------------------------
    ser_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (CW'(WIDTH - 1)),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef SER_PARITY_EN
    // Parity of the incoming word, built as a prefix XOR chain; the last
    // element is the even-parity bit latched at accept time.
    logic [WIDTH-1:0] par_chain;
    logic             parity_reg;
    logic             parity_next;

    assign par_chain[0] = data_in[0];
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_par_chain
        assign par_chain[gi] = par_chain[gi-1] ^ data_in[gi];
    end

    assign last_bit = (state_reg == S_PARITY);
`else
    assign last_bit = (state_reg == S_SHIFT) && cnt_zero;
`endif

    // Ready in idle or on the final bit of a frame; held low in reset.
    assign data_ready = rstn && ((state_reg == S_IDLE) || last_bit);
    assign accept     = data_valid && data_ready;

    // ------------------------------------------------------------------
    // Next-state and next-output logic. The registered outputs describe
    // what ser_out carries in the cycle after the edge, so every branch
    // computes the values for the *next* bit.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        ser_out_next    = IDLE_BIT;
        ser_active_next = 1'b0;
        word_done_next  = 1'b0;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
`ifdef SER_PARITY_EN
        parity_next     = parity_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                state_next = S_IDLE;
            end

            S_SHIFT: begin
                if (!cnt_zero) begin
                    state_next      = S_SHIFT;
                    ser_out_next    = shift_reg[WIDTH-1];
                    ser_active_next = 1'b1;
                    shift_next      = {shift_reg[WIDTH-2:0], 1'b0};
                    cnt_dec         = 1'b1;
`ifndef SER_PARITY_EN
                    // Count of 1 now means the LSB goes out next.
                    word_done_next  = (cnt_val == CW'(1));
`endif
                end else begin
`ifdef SER_PARITY_EN
                    state_next      = S_PARITY;
                    ser_out_next    = parity_reg;
                    ser_active_next = 1'b1;
                    word_done_next  = 1'b1;
`else
                    state_next      = S_IDLE;
`endif
                end
            end

            S_PARITY: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A handshake can only happen in idle or on the last bit, so it
        // overrides whatever the frame would otherwise have done next.
        if (accept) begin
            state_next      = S_SHIFT;
            ser_out_next    = data_in[WIDTH-1];
            ser_active_next = 1'b1;
            word_done_next  = 1'b0;
            shift_next      = {data_in[WIDTH-2:0], 1'b0};
            cnt_load        = 1'b1;
            cnt_dec         = 1'b0;
`ifdef SER_PARITY_EN
            parity_next     = par_chain[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_IDLE;
            shift_reg      <= '0;
            ser_out_reg    <= IDLE_BIT;
            ser_active_reg <= 1'b0;
            word_done_reg  <= 1'b0;
`ifdef SER_PARITY_EN
            parity_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            ser_out_reg    <= ser_out_next;
            ser_active_reg <= ser_active_next;
            word_done_reg  <= word_done_next;
`ifdef SER_PARITY_EN
            parity_reg     <= parity_next;
`endif
        end
    end

    assign ser_out    = ser_out_reg;
    assign ser_active = ser_active_reg;
    assign word_done  = word_done_reg;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// ----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. dut0 uses IDLE_BIT=0 and carries all
// traffic; dut1 uses IDLE_BIT=1 and stays idle to show the idle level.
// ----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] data_in0;
    logic         data_valid0;
    logic         data_ready0;
    logic         ser_out0;
    logic         ser_active0;
    logic         word_done0;
    logic [W-1:0] data_in1;
    logic         data_valid1;
    logic         data_ready1;
    logic         ser_out1;
    logic         ser_active1;
    logic         word_done1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .data_in    (data_in0),
        .data_valid (data_valid0),
        .data_ready (data_ready0),
        .ser_out    (ser_out0),
        .ser_active (ser_active0),
        .word_done  (word_done0)
    );

    piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .data_in    (data_in1),
        .data_valid (data_valid1),
        .data_ready (data_ready1),
        .ser_out    (ser_out1),
        .ser_active (ser_active1),
        .word_done  (word_done1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn        = 1'b1;
        data_in0    = 8'hC3;
        data_valid0 = 1'b1;
        data_in1    = 8'h00;
        data_valid1 = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        vectors++; if (data_ready0 !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", data_ready0); end
        vectors++; if (ser_out0 !== 1'b0) begin miscompares++; $display("FAIL reset_ser_out0: got %b want 0", ser_out0); end
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b want 0", ser_active0); end
        vectors++; if (word_done0 !== 1'b0) begin miscompares++; $display("FAIL reset_word_done: got %b want 0", word_done0); end
        vectors++; if (ser_out1 !== 1'b1) begin miscompares++; $display("FAIL reset_ser_out1: got %b want 1", ser_out1); end
        repeat (3) tick();
        // data_valid was high throughout reset: nothing may have been taken.
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept: active=%b want 0", ser_active0); end
        vectors++; if (data_ready0 !== 1'b0) begin miscompares++; $display("FAIL reset_ready_hold: got %b want 0", data_ready0); end
        data_valid0 = 1'b0;
        rstn        = 1'b1;
        #1;
        vectors++; if (data_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", data_ready0); end
        $display("reset released, dut0 idle");
    endtask

    task automatic test_single;
        logic [W-1:0] w;
        logic         exp;
        w           = 8'hA5;
        data_in0    = w;
        data_valid0 = 1'b1;
        vectors++; if (data_ready0 !== 1'b1) begin miscompares++; $display("FAIL single_ready_pre: got %b want 1", data_ready0); end
        tick();
        data_valid0 = 1'b0;
        data_in0    = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            exp = (i < W) ? w[W-1-i] : ^w;
            vectors++; if (ser_out0 !== exp) begin miscompares++; $display("FAIL single_bit%0d: ser_out=%b want %b", i, ser_out0, exp); end
            vectors++; if (ser_active0 !== 1'b1) begin miscompares++; $display("FAIL single_active%0d: got %b want 1", i, ser_active0); end
            vectors++; if (word_done0 !== (i == FRAME-1)) begin miscompares++; $display("FAIL single_done%0d: got %b want %b", i, word_done0, (i == FRAME-1)); end
            vectors++; if (data_ready0 !== (i == FRAME-1)) begin miscompares++; $display("FAIL single_ready%0d: got %b want %b", i, data_ready0, (i == FRAME-1)); end
            tick();
        end
        vectors++; if (ser_out0 !== 1'b0) begin miscompares++; $display("FAIL single_idle_out: got %b want 0", ser_out0); end
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL single_idle_active: got %b want 0", ser_active0); end
        vectors++; if (word_done0 !== 1'b0) begin miscompares++; $display("FAIL single_idle_done: got %b want 0", word_done0); end
        vectors++; if (data_ready0 !== 1'b1) begin miscompares++; $display("FAIL single_idle_ready: got %b want 1", data_ready0); end
        $display("word %h serialised", w);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [W-1:0] w;
        logic         exp;
        int           k;
        w0          = 8'hAA;
        w1          = 8'h55;
        data_in0    = w0;
        data_valid0 = 1'b1;
        tick();
        for (int i = 0; i < 2*FRAME; i++) begin
            w   = (i < FRAME) ? w0 : w1;
            k   = i % FRAME;
            exp = (k < W) ? w[W-1-k] : ^w;
            vectors++; if (ser_out0 !== exp) begin miscompares++; $display("FAIL b2b_bit%0d: ser_out=%b want %b", i, ser_out0, exp); end
            vectors++; if (ser_active0 !== 1'b1) begin miscompares++; $display("FAIL b2b_active%0d: got %b want 1", i, ser_active0); end
            vectors++; if (word_done0 !== (k == FRAME-1)) begin miscompares++; $display("FAIL b2b_done%0d: got %b want %b", i, word_done0, (k == FRAME-1)); end
            if (i == FRAME-1) data_in0 = w1;
            if (i == FRAME) data_valid0 = 1'b0;
            tick();
        end
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_active: got %b want 0", ser_active0); end
        vectors++; if (ser_out0 !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_out: got %b want 0", ser_out0); end
        $display("words %h,%h serialised back-to-back", w0, w1);
    endtask

    task automatic test_holdoff;
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [W-1:0] w;
        logic         exp;
        int           k;
        w0          = 8'h3C;
        w1          = 8'hC1;
        data_in0    = w0;
        data_valid0 = 1'b1;
        tick();
        for (int i = 0; i < 2*FRAME; i++) begin
            w   = (i < FRAME) ? w0 : w1;
            k   = i % FRAME;
            exp = (k < W) ? w[W-1-k] : ^w;
            vectors++; if (ser_out0 !== exp) begin miscompares++; $display("FAIL holdoff_bit%0d: ser_out=%b want %b", i, ser_out0, exp); end
            vectors++; if (data_ready0 !== (k == FRAME-1)) begin miscompares++; $display("FAIL holdoff_ready%0d: got %b want %b", i, data_ready0, (k == FRAME-1)); end
            // Junk on data_in with valid high outside the accept window.
            if (i == FRAME-1)       data_in0 = w1;
            else                    data_in0 = 8'(i * 29 + 7);
            if (i == 2*FRAME-1)     data_valid0 = 1'b0;
            tick();
        end
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL holdoff_idle_active: got %b want 0", ser_active0); end
        $display("words %h,%h serialised with hold-off traffic", w0, w1);
    endtask

    task automatic test_reset_mid;
        data_in0    = 8'hF0;
        data_valid0 = 1'b1;
        tick();
        data_valid0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (ser_out0 !== 1'b1) begin miscompares++; $display("FAIL mid_bit%0d: ser_out=%b want 1", i, ser_out0); end
            tick();
        end
        rstn = 1'b0;
        #1;
        vectors++; if (ser_out0 !== 1'b0) begin miscompares++; $display("FAIL mid_async_out: got %b want 0", ser_out0); end
        vectors++; if (data_ready0 !== 1'b0) begin miscompares++; $display("FAIL mid_async_ready: got %b want 0", data_ready0); end
        vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL mid_async_active: got %b want 0", ser_active0); end
        tick();
        tick();
        rstn = 1'b1;
        #1;
        vectors++; if (data_ready0 !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %b want 1", data_ready0); end
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++; if ((ser_active0 !== 1'b0) || (ser_out0 !== 1'b0)) begin miscompares++; $display("FAIL mid_residual%0d: active=%b out=%b want 0,0", i, ser_active0, ser_out0); end
        end
        $display("word f0 aborted by reset after 3 bits");
    endtask

    task automatic test_idle_level;
        for (int i = 0; i < 20; i++) begin
            vectors++; if ((ser_out1 !== 1'b1) || (ser_active1 !== 1'b0) || (data_ready1 !== 1'b1)) begin
                miscompares++;
                $display("FAIL idle1_cycle%0d: out=%b active=%b ready=%b want 1,0,1", i, ser_out1, ser_active1, data_ready1);
            end
            tick();
        end
        $display("idle level 1 held for 20 cycles");
    endtask

    task automatic test_parity_frames;
        logic [W-1:0]     words [2];
        logic [FRAME-1:0] expv  [2];
        logic             exp;
        words[0] = 8'h07;
        words[1] = 8'h03;
`ifdef SER_PARITY_EN
        expv[0] = 9'b0_0000_1111;
        expv[1] = 9'b0_0000_0110;
`else
        expv[0] = 8'b0000_0111;
        expv[1] = 8'b0000_0011;
`endif
        for (int n = 0; n < 2; n++) begin
            data_in0    = words[n];
            data_valid0 = 1'b1;
            tick();
            data_valid0 = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                exp = expv[n][FRAME-1-i];
                vectors++; if (ser_out0 !== exp) begin miscompares++; $display("FAIL frame%0d_bit%0d: ser_out=%b want %b", n, i, ser_out0, exp); end
                vectors++; if (word_done0 !== (i == FRAME-1)) begin miscompares++; $display("FAIL frame%0d_done%0d: got %b want %b", n, i, word_done0, (i == FRAME-1)); end
                tick();
            end
            vectors++; if (ser_active0 !== 1'b0) begin miscompares++; $display("FAIL frame%0d_end: active=%b want 0", n, ser_active0); end
            $display("word %h framed in %0d cycles", words[n], FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_holdoff();
        test_reset_mid();
        test_idle_level();
        test_parity_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_piso_serializer
